// File: rtl/seg7_scan_controller_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment controller:
// FSM states, datapath widths, active-low segment patterns and the BCD adjust step.
package seg7_scan_controller_pkg;

    localparam int BIN_W  = 13;
    localparam int DIGITS = 4;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int STEP_W = 4;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_e;

    // Active-low, bit6 = a ... bit0 = g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Double-dabble correction applied before each shift: nibbles >= 5 get +3.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern decoder.
// Codes 10..15 never occur in committed digits and fall back to blank.
module seg7_decode
    import seg7_scan_controller_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Loads a 13-bit binary value, converts it to BCD by serial double-dabble and
// multiplexes the committed digits onto a 4-digit common-anode display.
module seg7_scan_controller
    import seg7_scan_controller_pkg::*;
#(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BIN_W-1:0]  num,
    input  logic              num_valid,
    output logic              num_ready,
    output logic              busy,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        segments
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // Assertion passes straight through; release is delayed two clocks.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_int_n = rst_sync_q[1];

    state_e            state_q, state_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [BCD_W-1:0]  digits_q, digits_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [BCD_W-1:0]  bcd_adj;
    logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]        idx_q, idx_d;

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        step_d    = step_q;
        digits_d  = digits_q;
        bcd_adj   = dabble_adjust(bcd_q);
        num_ready = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                num_ready = 1'b1;
                if (num_valid) begin
                    bin_d   = num;
                    bcd_d   = '0;
                    step_d  = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                busy           = 1'b1;
                {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
                step_d         = step_q + 1'b1;
                if (step_q == STEP_LAST) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                busy     = 1'b1;
                digits_d = bcd_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan timing is free-running; commits only change what the slots show.
    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_cnt_q == CNT_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            digits_q   <= '0;
            step_q     <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            digits_q   <= digits_d;
            step_q     <= step_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
        end
    end

    // A digit is blank when it and every digit above it are zero; ones never blanks.
    logic [DIGITS-1:0] blank;
    logic              zero_above;

    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (digits_q[4*i +: 4] == 4'd0);
            blank[i]   = BLANK_LEADING && zero_above;
        end
    end

    logic [3:0] cur_digit;
    logic [6:0] dec_seg;

    assign cur_digit = digits_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_decode (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    assign anode    = blank[idx_q] ? {DIGITS{1'b1}} : ~(DIGITS'(1) << idx_q);
    assign segments = blank[idx_q] ? SEG_BLANK : dec_seg;

endmodule
